// File: rtl/rx_4ph_fifo_if.sv
// Bundle of the 4-phase push channel and the synchronous valid/ready read port
// of rx_4ph_fifo. The master modport is the producer/consumer side, slave is the FIFO.
interface rx_4ph_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             req_in;
  logic             ack_out;
  logic [WIDTH-1:0] data_in;
  logic             dout_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout_data;
  logic [LW-1:0]    level;
  logic             full;

  modport master (
    output req_in, data_in, dout_ready,
    input  ack_out, dout_valid, dout_data, level, full
  );

  modport slave (
    input  req_in, data_in, dout_ready,
    output ack_out, dout_valid, dout_data, level, full
  );
endinterface

// File: rtl/rx_4ph_fifo.sv
// Clocked consumer of a 4-phase bundled-data push channel feeding a show-ahead FIFO.
// Define RX_4PH_SYNC3_EN for a 3-flop request synchronizer (default is 2 flops).
//
// state  | meaning
// S_IDLE | ack low; capture the word once req_s is high and the FIFO has room
// S_ACK  | ack high; wait for the synchronized request to return low
module rx_4ph_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rstn,
  rx_4ph_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

`ifdef RX_4PH_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [SYNC_N-1:0] sync_q;
  logic              req_s;
  logic              wr_en, rd_en, full_w, empty_w;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  // data_in is bundled with req_in and deliberately not synchronized
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_N-2:0], bus.req_in};
  end

  assign req_s   = sync_q[SYNC_N-1];
  assign full_w  = (level_q == FULL_LVL);
  assign empty_w = (level_q == '0);
  assign rd_en   = !empty_w && bus.dout_ready;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // a full FIFO holds the FSM in S_IDLE, retrying the write every cycle
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && !full_w) begin
          wr_en   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.ack_out    = (state_q == S_ACK);
  assign bus.dout_valid = !empty_w;
  assign bus.dout_data  = mem[rd_ptr];
  assign bus.level      = level_q;
  assign bus.full       = full_w;
endmodule

// File: tb/tb_rx_4ph_fifo.sv
// Self-checking bench for rx_4ph_fifo: directed scenarios plus a randomized run,
// with an in-order word queue as the reference model.
module tb_rx_4ph_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef RX_4PH_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rx_4ph_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  rx_4ph_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int fails = 0;
  int rx_count = 0;
  int max_level = 0;
  bit rand_rdy = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  // scoreboard: a read fires at the next edge when valid and ready are both high
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
      if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
        logic [WIDTH-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL read_unexpected: dout_data=%h, required no word", bus.dout_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout_data !== e) begin
            fails++;
            $display("FAIL read_order: dout_data=%h, required %h", bus.dout_data, e);
          end
        end
        rx_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic req_rise(input logic [WIDTH-1:0] d, input int budget, output int lat);
    int n = 0;
    bus.data_in = d;
    bus.req_in  = 1'b1;
    exp_q.push_back(d);
    while (bus.ack_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    lat = n;
    checks++;
    if (bus.ack_out !== 1'b1) begin
      fails++;
      $display("FAIL ack_rise_timeout: ack_out=%b after %0d edges, required 1", bus.ack_out, n);
    end
  endtask

  task automatic req_fall(input int budget, output int lat);
    int n = 0;
    bus.req_in = 1'b0;
    while (bus.ack_out !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    lat = n;
    checks++;
    if (bus.ack_out !== 1'b0) begin
      fails++;
      $display("FAIL ack_fall_timeout: ack_out=%b after %0d edges, required 0", bus.ack_out, n);
    end
  endtask

  task automatic handshake(input logic [WIDTH-1:0] d, input int budget);
    int l;
    req_rise(d, budget, l);
    req_fall(budget, l);
  endtask

  task automatic drain();
    int n = 0;
    bus.dout_ready = 1'b1;
    while (bus.dout_valid === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    bus.dout_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.level !== 3'd0) begin
      fails++;
      $display("FAIL drain: level=%0d pending=%0d, required 0 and 0", bus.level, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.ack_out !== 1'b0 || bus.dout_valid !== 1'b0 || bus.level !== 3'd0 || bus.full !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ack=%b valid=%b level=%0d full=%b, required 0 0 0 0",
               bus.ack_out, bus.dout_valid, bus.level, bus.full);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lr, lf;
    bus.dout_ready = 1'b0;
    req_rise(8'hA5, 50, lr);
    checks++;
    if (lr != LAT) begin
      fails++;
      $display("FAIL single_rise_latency: %0d edges, required %0d", lr, LAT);
    end
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout_data !== 8'hA5 || bus.level !== 3'd1) begin
      fails++;
      $display("FAIL single_word: valid=%b data=%h level=%0d, required 1 a5 1",
               bus.dout_valid, bus.dout_data, bus.level);
    end
    req_fall(50, lf);
    checks++;
    if (lf != LAT) begin
      fails++;
      $display("FAIL single_fall_latency: %0d edges, required %0d", lf, LAT);
    end
    repeat (5) tick();
    checks++;
    if (bus.dout_data !== 8'hA5 || bus.level !== 3'd1) begin
      fails++;
      $display("FAIL single_hold: data=%h level=%0d, required a5 1", bus.dout_data, bus.level);
    end
    drain();
  endtask

  task automatic test_fill_full();
    int stray = 0;
    bus.dout_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) handshake(WIDTH'(i), 50);
    checks++;
    if (bus.full !== 1'b1 || bus.level !== 3'd4) begin
      fails++;
      $display("FAIL fill_full: full=%b level=%0d, required 1 4", bus.full, bus.level);
    end
    bus.data_in = 8'h05;
    bus.req_in  = 1'b1;
    exp_q.push_back(8'h05);
    repeat (20) begin
      tick();
      if (bus.ack_out !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || bus.level !== 3'd4) begin
      fails++;
      $display("FAIL full_stall: ack high on %0d cycles level=%0d, required 0 4", stray, bus.level);
    end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++;
    if (bus.ack_out !== 1'b0 || bus.level !== 3'd3) begin
      fails++;
      $display("FAIL full_pop_edge: ack=%b level=%0d, required 0 3", bus.ack_out, bus.level);
    end
    tick();
    checks++;
    if (bus.ack_out !== 1'b1 || bus.level !== 3'd4 || bus.dout_data !== 8'h02) begin
      fails++;
      $display("FAIL full_retry_write: ack=%b level=%0d head=%h, required 1 4 02",
               bus.ack_out, bus.level, bus.dout_data);
    end
    begin
      int lf;
      req_fall(50, lf);
    end
    drain();
  endtask

  task automatic test_wrap();
    int rx0 = rx_count;
    max_level = 0;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) handshake(WIDTH'(8'h10 + i), 50);
    repeat (3) tick();
    bus.dout_ready = 1'b0;
    checks++;
    if (max_level > 1 || rx_count - rx0 != 10 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap: max_level=%0d words=%0d pending=%0d, required <=1 10 0",
               max_level, rx_count - rx0, exp_q.size());
    end
  endtask

  task automatic test_simul();
    int lf;
    bus.dout_ready = 1'b0;
    handshake(8'h30, 50);
    handshake(8'h31, 50);
    bus.data_in = 8'h32;
    bus.req_in  = 1'b1;
    exp_q.push_back(8'h32);
    repeat (LAT - 1) tick();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++;
    if (bus.ack_out !== 1'b1 || bus.level !== 3'd2 || bus.dout_data !== 8'h31) begin
      fails++;
      $display("FAIL simul_rw: ack=%b level=%0d head=%h, required 1 2 31",
               bus.ack_out, bus.level, bus.dout_data);
    end
    req_fall(50, lf);
    drain();
  endtask

  task automatic test_reset_mid();
    int l, n;
    bus.dout_ready = 1'b0;
    handshake(8'h40, 50);
    handshake(8'h41, 50);
    req_rise(8'h42, 50, l);
    checks++;
    if (bus.level !== 3'd3 || bus.ack_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_setup: level=%0d ack=%b, required 3 1", bus.level, bus.ack_out);
    end
    rstn = 1'b0;
    tick();
    exp_q.delete();
    checks++;
    if (bus.ack_out !== 1'b0 || bus.level !== 3'd0 || bus.dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_flush: ack=%b level=%0d valid=%b, required 0 0 0",
               bus.ack_out, bus.level, bus.dout_valid);
    end
    rstn = 1'b1;
    exp_q.push_back(8'h42);
    n = 0;
    while (bus.ack_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != LAT || bus.level !== 3'd1 || bus.dout_data !== 8'h42) begin
      fails++;
      $display("FAIL reset_mid_recapture: edges=%0d level=%0d data=%h, required %0d 1 42",
               n, bus.level, bus.dout_data, LAT);
    end
    req_fall(50, l);
    drain();
  endtask

  task automatic test_random();
    int rx0 = rx_count;
    max_level = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      handshake(WIDTH'($urandom), 1000);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rdy = 1'b0;
    drain();
    checks++;
    if (rx_count - rx0 != 40 || max_level > DEPTH) begin
      fails++;
      $display("FAIL random: words=%0d max_level=%0d, required 40 <=%0d",
               rx_count - rx0, max_level, DEPTH);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_in     = 1'b0;
    bus.data_in    = '0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_full();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
